matrix_slot_writer: RTL and testbench
=====================================

# matrix_slot_writer

Consumer of the compute subsystem's result-write handshake. It accepts one matrix per request: ID, dimensions, an 8-byte name and a stream of `rows*cols` data words. It writes the matrix into its slot of the shared matrix BRAM, with the header committed last, and keeps a per-slot name table that the display/list logic reads. The block sits between the compute subsystem's `write_*` interface and the BRAM write port.

## Interface
- `BLOCK_SIZE`, 1152, words per slot; slot base address = `id*BLOCK_SIZE`.
- `NUM_SLOTS`, 8, number of valid matrix IDs (0..NUM_SLOTS-1).
- `DATA_WIDTH`, 32, data/BRAM word width.
- `ADDR_WIDTH`, 14, BRAM address width.
- `TIMEOUT_CYCLES`, 4096, idle-beat limit in STREAM; used only with `WRITER_TIMEOUT_EN`.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `write_request` in 1 — start-of-matrix strobe; sampled only while `write_ready`=1.
- `write_ready` out 1 — idle, request accepted.
- `write_matrix_id` in 3 — destination slot.
- `write_rows` in 8, `write_cols` in 8 — dimensions.
- `write_name` in 8x8 (array [0:7]) — name bytes.
- `write_data` in DATA_WIDTH — data beat.
- `write_data_valid` in 1 — beat strobe; accepted only while `writer_ready`=1.
- `writer_ready` out 1 — STREAM state, beats accepted.
- `write_done` out 1 — one-cycle completion pulse, for both success and error.
- `write_error` out 1 — high only in the `write_done` cycle of a rejected or aborted write.
- `bram_wr_en` out 1, `bram_wr_addr` out ADDR_WIDTH, `bram_wr_data` out DATA_WIDTH — registered BRAM write port.
- `name_rd_id` in 3, `name_rd_data` out 64 — combinational name-table read; `{name[0],...,name[7]}`, with `name[0]` in the MSBs.

## Operation
- States: IDLE, CHECK, INVALIDATE, STREAM, HDR0, HDR1, DONE, ERR.
- IDLE: `write_request`=1 latches ID, rows, cols and name; go to CHECK.
- CHECK: compute `count=rows*cols` (16-bit) and `base=id*BLOCK_SIZE`.
  - Reject if any of: `rows`=0, `cols`=0, `id`>=NUM_SLOTS, or `count+2`>BLOCK_SIZE.
  - Reject → ERR. Pass → INVALIDATE.
- INVALIDATE: write 0 to `base`. Readers then see the slot as empty (rows=0) while data is overwritten.
- STREAM: each accepted beat writes `write_data` to `base+2+idx`, then `idx++`. When the beat with `idx=count-1` is accepted → HDR0.
- HDR0: write `{rows,cols,16'h0000}` to `base`.
- HDR1: write 0 to `base+1` (reserved). Also load the name into `name_table[id]`.
- DONE: `write_done`=1 → IDLE.
- ERR: `write_done`=1, `write_error`=1, no BRAM writes, name table untouched → IDLE.
- `write_request` outside IDLE: ignored. Input fields are not re-sampled.
- `write_data_valid` outside STREAM, or beats beyond `count`: dropped, no write.
- Reset mid-operation: state returns to IDLE at once. The slot header stays 0 if reset lands after INVALIDATE and before HDR0. Reset never leaves a partially written header.

## Timing
- Reset values:
  - `write_ready`=1.
  - `writer_ready`, `write_done`, `write_error`, `bram_wr_en`=0.
  - `bram_wr_addr`, `bram_wr_data`=0.
  - All 8 name-table entries = 0.
- `write_ready`=(state==IDLE) and `writer_ready`=(state==STREAM) are decoded combinationally from state. All other outputs are registered.
- Request accepted at edge T:
  - CHECK occupies T..T+1.
  - INVALIDATE write is visible (`bram_wr_en`=1) during cycle T+2..T+3.
  - `writer_ready` rises at T+2 and falls when STREAM is left.
- Beat accepted at edge B → `bram_wr_en` high for cycle B..B+1 with that beat's address/data. Back-to-back beats are allowed, one per cycle.
- Last beat at edge L → HDR0 write in cycle L+1, HDR1 in L+2, `write_done` in L+3. `write_ready` returns at L+4.
- Error: request at T → `write_done`/`write_error` pulse at T+2; `write_ready` returns at T+3.
- Minimum turnaround for a 2x2 matrix: request to `write_done` = 9 cycles at full beat rate.

## Configuration
- `WRITER_TIMEOUT_EN` defined:
  - A 13-bit counter clears on each accepted beat and counts every STREAM cycle without one.
  - Reaching `TIMEOUT_CYCLES` → ERR. The header stays 0 and the name table is unchanged.
- Undefined: no counter; STREAM waits indefinitely.

## Test plan
- 2x2 to ID 1, beats 1,2,3,4 back-to-back:
  - Writes 0@1152, then 1..4@1154..1157, then `{2,2,0}`@1152 and 0@1153.
  - `write_done` 1 cycle, `write_error`=0.
  - `name_rd_id`=1 returns the name.
- 8x10 to ID 3 with a gap after every beat:
  - 80 data writes at 3458..3537, header `{8,10,0}`@3456 written last.
  - `writer_ready` low after the 80th beat.
- Rejects: `rows`=0; then 32x36 (1152+2 > 1152).
  - Each gives `write_done`+`write_error` pulse at T+2.
  - `bram_wr_en` never asserts; name table unchanged.
- Busy-path stimulus: second `write_request` and extra `write_data_valid` beats during a 2x2 write.
  - Both ignored; exactly 4 data writes; no second `write_done`.
- Reset mid-stream: assert `rst` after 2 of 4 beats.
  - Outputs return to reset values; header@base remains 0.
  - Next request completes normally.
- With `WRITER_TIMEOUT_EN`: stop beats after 1 of 4.
  - `write_error` pulse `TIMEOUT_CYCLES` cycles later; header remains 0.
  - Without the macro: no pulse within 10000 cycles.

Source files
------------

// File: rtl/matrix_slot_writer.sv
// Writes one matrix per request into its BRAM slot (data first, header last) and keeps the slot name table.
// Define WRITER_TIMEOUT_EN to abort a stalled STREAM after TIMEOUT_CYCLES idle beats.
module matrix_slot_writer #(
    parameter int BLOCK_SIZE     = 1152,
    parameter int NUM_SLOTS      = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            write_matrix_id,
    input  logic [7:0]            write_rows,
    input  logic [7:0]            write_cols,
    input  logic [7:0]            write_name [0:7],
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    input  logic [2:0]            name_rd_id,
    output logic [63:0]           name_rd_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_INVAL  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_HDR0   = 3'd4;
    localparam logic [2:0] S_HDR1   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    logic [2:0]            r_state;
    logic [2:0]            r_id;
    logic [7:0]            r_rows;
    logic [7:0]            r_cols;
    logic [63:0]           r_name;
    logic [15:0]           r_idx;
    logic                  r_done;
    logic                  r_err;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [63:0]           r_name_table [0:7];

    logic [15:0]           w_count;
    logic [ADDR_WIDTH-1:0] w_base;
    logic                  w_reject;
    logic                  w_last;
    logic                  w_tmo_hit;

    assign w_count  = {8'd0, r_rows} * {8'd0, r_cols};
    assign w_base   = ADDR_WIDTH'(r_id) * ADDR_WIDTH'(BLOCK_SIZE);
    assign w_last   = (r_idx == w_count - 16'd1);
    assign w_reject = (r_rows == 8'd0) || (r_cols == 8'd0)
                   || (int'(r_id) >= NUM_SLOTS)
                   || (({1'b0, w_count} + 17'd2) > 17'(BLOCK_SIZE));

`ifdef WRITER_TIMEOUT_EN
    logic [12:0] r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state != S_STREAM || write_data_valid) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 13'd1;
        end
    end

    assign w_tmo_hit = (r_tmo == 13'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_rows    <= '0;
            r_cols    <= '0;
            r_name    <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < 8; i++) begin
                r_name_table[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_wr_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (write_request) begin
                        r_id    <= write_matrix_id;
                        r_rows  <= write_rows;
                        r_cols  <= write_cols;
                        r_name  <= {write_name[0], write_name[1],
                                    write_name[2], write_name[3],
                                    write_name[4], write_name[5],
                                    write_name[6], write_name[7]};
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_state <= w_reject ? S_ERR : S_INVAL;
                end
                S_INVAL: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_base;
                    r_wr_data <= '0;
                    r_idx     <= '0;
                    r_state   <= S_STREAM;
                end
                S_STREAM: begin
                    if (write_data_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_base + ADDR_WIDTH'(2) + ADDR_WIDTH'(r_idx);
                        r_wr_data <= write_data;
                        r_idx     <= r_idx + 16'd1;
                        if (w_last) begin
                            r_state <= S_HDR0;
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= S_ERR;
                    end
                end
                S_HDR0: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_base;
                    r_wr_data <= DATA_WIDTH'({r_rows, r_cols, 16'h0000});
                    r_state   <= S_HDR1;
                end
                S_HDR1: begin
                    r_wr_en              <= 1'b1;
                    r_wr_addr            <= w_base + ADDR_WIDTH'(1);
                    r_wr_data            <= '0;
                    r_name_table[r_id]   <= r_name;
                    r_state              <= S_DONE;
                end
                // Hold DONE/ERR through the pulse so write_ready stays low during it
                S_DONE, S_ERR: begin
                    r_done <= !r_done;
                    r_err  <= (r_state == S_ERR) && !r_done;
                    if (r_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign write_ready  = (r_state == S_IDLE);
    assign writer_ready = (r_state == S_STREAM);
    assign write_done   = r_done;
    assign write_error  = r_err;
    assign bram_wr_en   = r_wr_en;
    assign bram_wr_addr = r_wr_addr;
    assign bram_wr_data = r_wr_data;
    assign name_rd_data = r_name_table[name_rd_id];

endmodule

// File: tb/tb_matrix_slot_writer.sv
// Directed bench for matrix_slot_writer: vector table plus busy, reset and timeout sequences.
`timescale 1ns/1ps
module tb_matrix_slot_writer;

    localparam int BS = 1152;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_request = 1'b0;
    logic        write_ready;
    logic [2:0]  write_matrix_id = '0;
    logic [7:0]  write_rows = '0;
    logic [7:0]  write_cols = '0;
    logic [7:0]  write_name [0:7];
    logic [31:0] write_data = '0;
    logic        write_data_valid = 1'b0;
    logic        writer_ready;
    logic        write_done;
    logic        write_error;
    logic        bram_wr_en;
    logic [13:0] bram_wr_addr;
    logic [31:0] bram_wr_data;
    logic [2:0]  name_rd_id = '0;
    logic [63:0] name_rd_data;

    matrix_slot_writer dut (
        .clk(clk), .rst(rst),
        .write_request(write_request), .write_ready(write_ready),
        .write_matrix_id(write_matrix_id),
        .write_rows(write_rows), .write_cols(write_cols),
        .write_name(write_name),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .writer_ready(writer_ready), .write_done(write_done),
        .write_error(write_error),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr),
        .bram_wr_data(bram_wr_data),
        .name_rd_id(name_rd_id), .name_rd_data(name_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic [7:0]  rows;
        logic [7:0]  cols;
        bit          gap;
        bit          err;
        logic [63:0] name;
    } vec_t;

    vec_t        vecs [8];
    logic [63:0] exp_names [8];
    logic [45:0] wr_q [$];
    int          done_seen = 0;
    int          errors = 0;
    int          checks = 0;

    always @(negedge clk) begin
        if (bram_wr_en) wr_q.push_back({bram_wr_addr, bram_wr_data});
        if (write_done) done_seen++;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_name(input logic [63:0] n);
        for (int i = 0; i < 8; i++) write_name[i] = n[63-8*i -: 8];
    endtask

    function automatic logic [31:0] dpat(input logic [2:0] id, input int i);
        return {5'd0, id, 8'h00, 16'(i + 1)};
    endfunction

    task automatic check_name(input logic [2:0] id);
        name_rd_id = id;
        #1;
        check($sformatf("name[%0d]", id), name_rd_data, exp_names[id]);
    endtask

    task automatic run_vec(input vec_t v);
        int          cnt, k, sent, done_k, n0;
        bit          got, gerr, drove, chk_low;
        logic [13:0] base;
        logic [45:0] exp_q [$];
        logic [45:0] act;
        cnt  = int'(v.rows) * int'(v.cols);
        base = 14'(int'(v.id) * BS);
        if (!v.err) begin
            exp_q.push_back({base, 32'h0});
            for (int i = 0; i < cnt; i++)
                exp_q.push_back({14'(int'(base) + 2 + i), dpat(v.id, i)});
            exp_q.push_back({base, v.rows, v.cols, 16'h0});
            exp_q.push_back({14'(int'(base) + 1), 32'h0});
        end
        n0 = wr_q.size();
        write_matrix_id = v.id;
        write_rows = v.rows;
        write_cols = v.cols;
        set_name(v.name);
        write_request = 1'b1;
        tick();
        write_request = 1'b0;
        k = 0; sent = 0; done_k = -1;
        got = 0; gerr = 0; drove = 0; chk_low = 0;
        while (!got && k < 5000) begin
            if (chk_low) begin
                check("writer_ready_after_last", writer_ready, 1'b0);
                chk_low = 0;
            end
            if (write_done) begin
                got = 1; done_k = k; gerr = write_error;
                check("ready_low_in_done", write_ready, 1'b0);
            end
            write_data_valid = 1'b0;
            if (!got && writer_ready && sent < cnt && !(v.gap && drove)) begin
                write_data_valid = 1'b1;
                write_data = dpat(v.id, sent);
                sent++;
                drove = 1;
                if (sent == cnt) chk_low = 1;
            end else begin
                drove = 0;
            end
            tick();
            k++;
        end
        write_data_valid = 1'b0;
        check("done_seen", got, 1'b1);
        check("write_error", gerr, v.err);
        if (v.err) check("err_latency", done_k, 2);
        else if (!v.gap) check("done_latency", done_k, cnt + 5);
        check("ready_return", {write_ready, write_done}, 2'b10);
        check("n_writes", wr_q.size() - n0, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            act = (n0 + j < wr_q.size()) ? wr_q[n0 + j] : 'x;
            check($sformatf("write[%0d]", j), act, exp_q[j]);
        end
        if (!v.err) exp_names[v.id] = v.name;
        check_name(v.id);
    endtask

    initial begin
        int          k, n0, d0;
        bit          got, gerr;
        logic [45:0] e;
        set_name('0);
        for (int i = 0; i < 8; i++) exp_names[i] = '0;
        vecs[0] = '{3'd1, 8'd2,  8'd2,  1'b0, 1'b0, "MATRIX_A"};
        vecs[1] = '{3'd3, 8'd8,  8'd10, 1'b1, 1'b0, "BIGGAP03"};
        vecs[2] = '{3'd6, 8'd0,  8'd4,  1'b0, 1'b1, "ZEROROWS"};
        vecs[3] = '{3'd2, 8'd32, 8'd36, 1'b0, 1'b1, "TOO_BIG!"};
        vecs[4] = '{3'd0, 8'd1,  8'd1,  1'b0, 1'b0, "ONE_BY_1"};
        vecs[5] = '{3'd7, 8'd25, 8'd46, 1'b0, 1'b0, "MAX_FIT7"};
        vecs[6] = '{3'd5, 8'd24, 8'd48, 1'b0, 1'b1, "OVER_BY2"};
        vecs[7] = '{3'd4, 8'd3,  8'd0,  1'b0, 1'b1, "ZEROCOLS"};

        #22 rst = 1'b0;
        tick();
        check("rst_write_ready", write_ready, 1'b1);
        check("rst_writer_ready", writer_ready, 1'b0);
        check("rst_done_err", {write_done, write_error}, 2'b00);
        check("rst_wr_en", bram_wr_en, 1'b0);
        check("rst_wr_addr", bram_wr_addr, 14'h0);
        check("rst_wr_data", bram_wr_data, 32'h0);
        for (int i = 0; i < 8; i++) check_name(3'(i));

        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v]);
            tick();
        end

        // Busy path: request held high and beats streamed the whole time
        n0 = wr_q.size();
        d0 = done_seen;
        write_matrix_id = 3'd2; write_rows = 8'd2; write_cols = 8'd2;
        set_name("FIRST_NM");
        write_request = 1'b1;
        tick();
        write_matrix_id = 3'd6; write_rows = 8'd3;
        set_name("SECOND!!");
        for (int c = 0; c < 9; c++) begin
            write_data_valid = 1'b1;
            write_data = 32'(100 + c);
            tick();
        end
        check("busy_done", write_done, 1'b1);
        write_request = 1'b0;
        write_data_valid = 1'b0;
        repeat (20) tick();
        check("busy_one_done", done_seen - d0, 1);
        check("busy_n_writes", wr_q.size() - n0, 7);
        for (int j = 0; j < 7; j++) begin
            case (j)
                0: e = {14'd2304, 32'h0};
                5: e = {14'd2304, 32'h02020000};
                6: e = {14'd2305, 32'h0};
                default: e = {14'(2304 + j + 1), 32'(101 + j)};
            endcase
            check($sformatf("busy_write[%0d]", j),
                  (n0 + j < wr_q.size()) ? wr_q[n0 + j] : 'x, e);
        end
        exp_names[2] = "FIRST_NM";
        check_name(3'd2);
        check_name(3'd6);

        // Reset after two of four beats
        n0 = wr_q.size();
        write_matrix_id = 3'd4; write_rows = 8'd2; write_cols = 8'd2;
        set_name("RSTMID04");
        write_request = 1'b1;
        tick();
        write_request = 1'b0;
        tick();
        tick();
        check("rst_seq_stream", writer_ready, 1'b1);
        write_data_valid = 1'b1; write_data = 32'hA0;
        tick();
        write_data_valid = 1'b1; write_data = 32'hA1;
        tick();
        write_data_valid = 1'b0;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) exp_names[i] = '0;
        check("midrst_ready", {write_ready, writer_ready}, 2'b10);
        check("midrst_pulses", {write_done, write_error, bram_wr_en}, 3'b000);
        check("midrst_port", {bram_wr_addr, bram_wr_data}, 46'h0);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_n_writes", wr_q.size() - n0, 2);
        for (int j = n0; j < wr_q.size(); j++)
            if (wr_q[j][45:32] == 14'd4608)
                check("midrst_hdr_zero", wr_q[j][31:0], 32'h0);
        check_name(3'd4);
        check_name(3'd2);
        run_vec('{3'd4, 8'd2, 8'd2, 1'b0, 1'b0, "AFTERRST"});
        tick();

        // Stalled stream: one beat of four
        n0 = wr_q.size();
        d0 = done_seen;
        write_matrix_id = 3'd5; write_rows = 8'd2; write_cols = 8'd2;
        set_name("STALL_05");
        write_request = 1'b1;
        tick();
        write_request = 1'b0;
        tick();
        tick();
        write_data_valid = 1'b1; write_data = 32'h55;
        tick();
        write_data_valid = 1'b0;
        k = 3; got = 0; gerr = 0;
`ifdef WRITER_TIMEOUT_EN
        while (!got && k < 6000) begin
            if (write_done) begin
                got = 1; gerr = write_error;
            end else begin
                tick();
                k++;
            end
        end
        check("tmo_done", got, 1'b1);
        check("tmo_error", gerr, 1'b1);
        check("tmo_latency_window", (k - 3 >= 4090) && (k - 3 <= 4110), 1'b1);
        tick();
        check("tmo_ready_return", write_ready, 1'b1);
        check("tmo_n_writes", wr_q.size() - n0, 2);
        for (int j = n0; j < wr_q.size(); j++)
            if (wr_q[j][45:32] == 14'd5760)
                check("tmo_hdr_zero", wr_q[j][31:0], 32'h0);
        check_name(3'd5);
`else
        repeat (10000) tick();
        check("no_tmo_done", done_seen - d0, 0);
        check("no_tmo_still_stream", writer_ready, 1'b1);
        check("no_tmo_n_writes", wr_q.size() - n0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) exp_names[i] = '0;
        tick();
        check("post_rst_ready", write_ready, 1'b1);
        check_name(3'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
